// File: rtl/rv_core_pkg.sv
// Shared core definitions: PC sequencer states, NOP encoding and default vectors.
package rv_core_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] INSTR_NOP            = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_REQ,
        ST_RESP,
        ST_HOLD,
        ST_TRAP
    } pcseq_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch handshake with a single outstanding request.
interface pc_sequencer_if;
    import rv_core_pkg::*;

    logic            req;
    logic [XLEN-1:0] addr;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);

endinterface

// File: rtl/pc_sequencer.sv
// Owns the architectural PC, fetches one instruction at a time and hands it to decode.
// Misaligned jump/branch targets raise a one-cycle trap and redirect to TRAP_VECTOR.
module pc_sequencer
    import rv_core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_target_i,
    pc_sequencer_if.master  imem,
    output logic [XLEN-1:0] instr_o,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            trap_o,
    output logic [XLEN-1:0] trap_addr_o
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    pcseq_state_e    r_state, w_state_d;
    logic [XLEN-1:0] r_pc, w_pc_d;
    logic [XLEN-1:0] r_instr, w_instr_d;
    logic [XLEN-1:0] r_pc_o, w_pc_o_d;
    logic [XLEN-1:0] r_pc_plus4;
    logic [XLEN-1:0] r_trap_addr, w_trap_addr_d;
    logic            r_req, r_valid, r_trap;
    logic [XLEN-1:0] w_next_pc;

    // Jump wins over branch; otherwise fall through to the next word.
    function automatic logic [XLEN-1:0] sel_next_pc(
        input logic            jump,
        input logic [XLEN-1:0] jump_target,
        input logic            taken,
        input logic [XLEN-1:0] branch_target,
        input logic [XLEN-1:0] pc
    );
        if (jump)       return jump_target;
        else if (taken) return branch_target;
        else            return pc + PC_STEP;
    endfunction

    assign w_next_pc = sel_next_pc(jump_i, jump_target_i, branch_taken_i, branch_target_i, r_pc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_BOOT;
        else        r_state <= w_state_d;
    end

    always_comb begin
        w_state_d     = r_state;
        w_pc_d        = r_pc;
        w_instr_d     = r_instr;
        w_pc_o_d      = r_pc_o;
        w_trap_addr_d = r_trap_addr;
        unique case (r_state)
            ST_BOOT: w_state_d = ST_REQ;
            // rvalid is deliberately ignored here so responses from before a reset are dropped.
            ST_REQ: begin
                if (imem.gnt) w_state_d = ST_RESP;
            end
            ST_RESP: begin
                if (imem.rvalid) begin
                    w_instr_d = imem.rdata;
                    w_pc_o_d  = r_pc;
                    w_state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!stall_i) begin
                    if (w_next_pc[1:0] != 2'b00) begin
                        w_trap_addr_d = w_next_pc;
                        w_state_d     = ST_TRAP;
                    end else begin
                        w_pc_d    = w_next_pc;
                        w_state_d = ST_REQ;
                    end
                end
            end
            ST_TRAP: begin
                w_pc_d    = TRAP_VECTOR;
                w_state_d = ST_REQ;
            end
            default: w_state_d = ST_BOOT;
        endcase
    end

    // Datapath and state-decoded outputs, registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_VECTOR;
            r_instr     <= INSTR_NOP;
            r_pc_o      <= RESET_VECTOR;
            r_pc_plus4  <= RESET_VECTOR + PC_STEP;
            r_trap_addr <= '0;
            r_req       <= 1'b0;
            r_valid     <= 1'b0;
            r_trap      <= 1'b0;
        end else begin
            r_pc        <= w_pc_d;
            r_instr     <= w_instr_d;
            r_pc_o      <= w_pc_o_d;
            r_pc_plus4  <= w_pc_o_d + PC_STEP;
            r_trap_addr <= w_trap_addr_d;
            r_req       <= (w_state_d == ST_REQ);
            r_valid     <= (w_state_d == ST_HOLD);
            r_trap      <= (w_state_d == ST_TRAP);
        end
    end

    assign imem.req      = r_req;
    assign imem.addr     = r_pc;
    assign instr_o       = r_instr;
    assign instr_valid_o = r_valid;
    assign pc_o          = r_pc_o;
    assign pc_plus4_o    = r_pc_plus4;
    assign trap_o        = r_trap;
    assign trap_addr_o   = r_trap_addr;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: fetch cadence, redirects, traps, stalls and reset.
module tb_pc_sequencer;
    import rv_core_pkg::*;

    localparam logic [31:0] RDATA_KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        jump_i;
    logic [31:0] jump_target_i;
    logic [31:0] instr_o;
    logic        instr_valid_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        trap_o;
    logic [31:0] trap_addr_o;

    int n_checks = 0;
    int n_errors = 0;

    pc_sequencer_if u_imem ();

    // Memory model: instruction word is a keyed copy of its address.
    assign u_imem.rdata = u_imem.addr ^ RDATA_KEY;

    pc_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .imem            (u_imem.master),
        .instr_o         (instr_o),
        .instr_valid_o   (instr_valid_o),
        .pc_o            (pc_o),
        .pc_plus4_o      (pc_plus4_o),
        .trap_o          (trap_o),
        .trap_addr_o     (trap_addr_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hold();
        bit seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            if (instr_valid_o === 1'b1) seen = 1'b1;
        end
        check("hold_reached", 32'(seen), 32'd1);
    endtask

    task automatic redirect(input logic jmp, input logic [31:0] jt,
                            input logic br, input logic [31:0] bt);
        jump_i = jmp; jump_target_i = jt;
        branch_taken_i = br; branch_target_i = bt;
        tick();
        jump_i = 1'b0; branch_taken_i = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req"},   32'(u_imem.req), 32'd0);
        check({tag, "_addr"},  u_imem.addr, 32'h0);
        check({tag, "_valid"}, 32'(instr_valid_o), 32'd0);
        check({tag, "_instr"}, instr_o, INSTR_NOP);
        check({tag, "_trap"},  32'(trap_o), 32'd0);
        check({tag, "_taddr"}, trap_addr_o, 32'h0);
        check({tag, "_pc4"},   pc_plus4_o, 32'h4);
    endtask

    initial begin
        rst_n = 1'b0; stall_i = 1'b0;
        branch_taken_i = 1'b0; branch_target_i = '0;
        jump_i = 1'b0; jump_target_i = '0;
        u_imem.gnt = 1'b1; u_imem.rvalid = 1'b1;

        tick(); tick();
        check_reset_vals("rst");
        rst_n = 1'b1;

        // Zero-wait-state fetch cadence from reset
        tick();
        check("f0_req", 32'(u_imem.req), 32'd1);
        check("f0_addr", u_imem.addr, 32'h0);
        check("f0_valid_low", 32'(instr_valid_o), 32'd0);
        tick();
        check("f0_resp_req", 32'(u_imem.req), 32'd0);
        tick();
        check("f0_valid", 32'(instr_valid_o), 32'd1);
        check("f0_instr", instr_o, 32'h0 ^ RDATA_KEY);
        check("f0_pc", pc_o, 32'h0);
        check("f0_pc4", pc_plus4_o, 32'h4);
        tick();
        check("f1_addr", u_imem.addr, 32'h4);
        check("f1_req", 32'(u_imem.req), 32'd1);
        tick(); tick(); tick();
        check("f2_addr", u_imem.addr, 32'h8);

        // Branch taken / not taken from pc 0x100
        wait_hold(); redirect(1'b1, 32'h100, 1'b0, 32'h0);
        check("jmp100_addr", u_imem.addr, 32'h100);
        wait_hold();
        check("hold100_pc", pc_o, 32'h100);
        redirect(1'b0, 32'h0, 1'b1, 32'h0F8);
        check("br_taken_addr", u_imem.addr, 32'h0F8);
        wait_hold(); redirect(1'b1, 32'h100, 1'b0, 32'h0);
        wait_hold(); redirect(1'b0, 32'h0, 1'b0, 32'h0F8);
        check("br_not_taken_addr", u_imem.addr, 32'h104);

        // Jump beats branch
        wait_hold(); redirect(1'b1, 32'h400, 1'b1, 32'h200);
        check("jmp_prio_addr", u_imem.addr, 32'h400);

        // Misaligned jump target traps
        wait_hold(); redirect(1'b1, 32'h402, 1'b0, 32'h0);
        check("trap_pulse", 32'(trap_o), 32'd1);
        check("trap_addr", trap_addr_o, 32'h402);
        check("trap_valid", 32'(instr_valid_o), 32'd0);
        check("trap_req", 32'(u_imem.req), 32'd0);
        tick();
        check("trap_end", 32'(trap_o), 32'd0);
        check("trap_vec_req", 32'(u_imem.req), 32'd1);
        check("trap_vec_addr", u_imem.addr, 32'h100);

        // Stall holds the instruction; only the release-cycle branch matters
        wait_hold();
        stall_i = 1'b1; branch_target_i = 32'h200;
        for (int i = 0; i < 5; i++) begin
            branch_taken_i = (i % 2 == 0);
            tick();
            check("stall_valid", 32'(instr_valid_o), 32'd1);
            check("stall_req", 32'(u_imem.req), 32'd0);
            check("stall_instr", instr_o, 32'h100 ^ RDATA_KEY);
            check("stall_pc", pc_o, 32'h100);
        end
        stall_i = 1'b0;
        redirect(1'b0, 32'h0, 1'b0, 32'h200);
        check("stall_release_addr", u_imem.addr, 32'h104);

        // Reset during RESP; a late response must be dropped
        u_imem.rvalid = 1'b0;
        tick();
        check("resp_req", 32'(u_imem.req), 32'd0);
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_resp");
        @(posedge clk); #1;
        rst_n = 1'b1; u_imem.gnt = 1'b0; u_imem.rvalid = 1'b1;
        tick();
        check("post_rst_req", 32'(u_imem.req), 32'd1);
        check("post_rst_addr", u_imem.addr, 32'h0);
        tick();
        check("stale_rvalid_ignored", 32'(instr_valid_o), 32'd0);
        check("stale_req_held", 32'(u_imem.req), 32'd1);
        u_imem.gnt = 1'b1;
        tick(); tick();
        check("post_rst_valid", 32'(instr_valid_o), 32'd1);
        check("post_rst_pc", pc_o, 32'h0);

        // Sequential wrap at the top of the address space
        redirect(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        wait_hold();
        check("wrap_pc4", pc_plus4_o, 32'h0);
        redirect(1'b0, 32'h0, 1'b0, 32'h0);
        check("wrap_addr", u_imem.addr, 32'h0);
        check("wrap_no_trap", 32'(trap_o), 32'd0);
        check("wrap_req", 32'(u_imem.req), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
